aes_sbox_pipe: RTL and testbench
================================

Name: aes_sbox_pipe

Overview:
- Multi-lane, pipelined AES byte-substitution engine.
- Applies either the forward S-box (SubBytes) or the inverse S-box (InvSubBytes) to LANES bytes per transaction.
- Valid/ready handshake on both sides, optional second register stage, synchronous flush.
- Shared substitution resource for the round datapath and the key-expansion logic: one instance serves a 32-bit key word (LANES=4) or a full 128-bit state (LANES=16).

Parameters:
- LANES, 4, number of independent byte lanes; legal 1..16.
- PIPE, 1, register stages; legal values 1 or 2; any other value is an elaboration error.
- TAG_W, 4, width of sideband tag carried alongside data unchanged; legal >=1.

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all in-flight transactions.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept input this cycle.
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; applies to all lanes of this transaction.
- in_data  input  8*LANES  lane k = in_data[8k+7:8k].
- in_tag  input  TAG_W  sideband, returned with result.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  8*LANES  substituted bytes, same lane order.
- out_tag  output  TAG_W  tag of the transaction.
- busy  output  1  any stage holds a valid transaction.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid flags 0; out_valid=0, out_data=0, out_tag=0, busy=0. in_ready=0 while rst=0; in_ready=1 from the first cycle after reset release. Reset mid-operation discards all in-flight transactions; none is ever presented.
- Transfer rules:
  - Input transfer occurs on a rising edge with in_valid & in_ready.
  - Output transfer occurs with out_valid & out_ready.
  - out_data/out_tag stay stable while out_valid=1 and out_ready=0.
- PIPE=1:
  - Lookup is combinational from the input; one result register.
  - Latency 1 cycle: accepted at edge N, out_valid=1 after edge N.
  - in_ready = !flush & (!out_valid | out_ready). Full throughput with back-to-back transfers.
- PIPE=2:
  - Stage A registers in_data/in_inv/in_tag. Lookup is combinational from stage A. Stage B registers the result.
  - Latency 2 cycles.
  - Each stage loads when it is empty or the next stage is draining in the same cycle: B advances = !B_valid | out_ready; A advances = !A_valid | B advances.
  - in_ready = !flush & A advances.
  - Sustains 1 transaction/cycle when out_ready is held at 1.
  - With out_ready=0 the pipeline holds exactly 2 transactions, then in_ready drops.
- Stalled stages keep their contents unchanged. No bubbles are inserted when a downstream slot frees in the same cycle.
- Flush (synchronous, active-high):
  - On an edge with flush=1, all valid flags clear.
  - in_ready=0 during the flush cycle, so no input is accepted even if in_valid=1.
  - If out_valid & out_ready & flush occur together, the output transfer counts as completed. All other in-flight work is dropped.
  - Data registers need not clear on flush.
- Mode is per-transaction: consecutive transactions may alternate in_inv with no stall or cross-contamination.
- busy = OR of stage valid flags.
- Lookup functions:
  - Forward: standard AES S-box.
  - Inverse: its exact inverse, so Inv(Fwd(x)) = x for all 256 values.
  - Each lane is independent; there is no cross-lane arithmetic.
- No X propagation: when in_valid=0, inputs are not captured into valid stages.

Decomposition:
- Package aes_pkg:
  - typedef aes_byte_t (8-bit logic).
  - enum sbox_mode_e {SBOX_FWD=1'b0, SBOX_INV=1'b1}.
  - localparam AES_MAX_LANES=16.
- Sub-module aes_sbox_lut:
  - Purely combinational: inputs a[7:0] and inv; output d[7:0]; forward and inverse 256-entry tables.
  - Instantiated LANES times by generate.
- aes_sbox_pipe itself contains only the handshake/pipeline control and registers.

Test Plan:
- LANES=4, PIPE=1: in_data=32'hFF53_0100, in_inv=0, tag=4'h5, out_ready=1 -> one cycle later out_data=32'h16ED_7C63, out_tag=4'h5, out_valid for 1 cycle.
- Same configuration, in_inv=1, in_data=32'h16ED_7C63 -> out_data=32'hFF53_0100. Exhaustively sweep all 256 bytes in lane 0, checking Fwd then Inv round-trip and Fwd(0x63)=0xFB.
- PIPE=2, out_ready=0, stream 3 transactions -> first two accepted, in_ready=0 on the third. Raise out_ready -> outputs in order with latency 2, then 1/cycle, and data is stable during the stall.
- PIPE=2, alternate in_inv 0/1 on back-to-back inputs 0x00, 0x63 -> outputs 0x63, 0x00 in consecutive cycles with correct tags.
- Two transactions in flight, assert flush one cycle -> in_ready=0 that cycle, both dropped, busy=0 next cycle, next input processed normally.
- Assert rst=0 asynchronously mid-stream (between edges) -> out_valid and busy fall immediately; after release no stale transaction emerges.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and limits for the AES byte-substitution datapath.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic {
    SBOX_FWD = 1'b0,
    SBOX_INV = 1'b1
  } sbox_mode_e;

  localparam int AES_MAX_LANES = 16;

endpackage

// File: rtl/aes_sbox_lut.sv
// Single-byte AES S-box: forward table held as a constant. The inverse table
// is derived from it when the design is built, so the two cannot disagree.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  aes_byte_t a,
  input  logic      inv,
  output aes_byte_t d
);

  // Entry 0 sits in the most significant byte; entry x lives at bit {~x, 3'b000}.
  localparam logic [2047:0] FWD_TAB = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [2047:0] invert_tab(input logic [2047:0] fwd);
    logic [2047:0] r;
    logic [7:0]    idx;
    logic [7:0]    s;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      idx = i[7:0];
      s   = fwd[{~idx, 3'b000} +: 8];
      r[{~s, 3'b000} +: 8] = idx;
    end
    return r;
  endfunction

  localparam logic [2047:0] INV_TAB = invert_tab(FWD_TAB);

  // Table select by mode; pure lookup, no state.
  always_comb begin
    if (sbox_mode_e'(inv) == SBOX_INV) begin
      d = INV_TAB[{~a, 3'b000} +: 8];
    end else begin
      d = FWD_TAB[{~a, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane AES SubBytes/InvSubBytes engine with valid/ready on both sides,
// one or two register stages and a synchronous flush.
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PIPE  = 1,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  logic               b_valid_q;
  logic [8*LANES-1:0] b_data_q;
  logic [TAG_W-1:0]   b_tag_q;
  logic [8*LANES-1:0] b_data_d;

  logic               lut_valid;
  logic               lut_inv;
  logic [8*LANES-1:0] lut_a;
  logic [TAG_W-1:0]   lut_tag;
  logic               a_valid;
  logic               up_adv;
  logic               b_adv;
  logic               accept;

  assign b_adv    = !b_valid_q || out_ready;
  assign in_ready = rst && !flush && up_adv;
  assign accept   = in_valid && in_ready;

  if ((LANES < 1) || (LANES > AES_MAX_LANES)) begin : g_bad_lanes
    $error("aes_sbox_pipe: LANES must be 1..%0d", AES_MAX_LANES);
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_sbox_pipe: TAG_W must be at least 1");
  end

  if (PIPE == 1) begin : g_pipe1
    assign up_adv    = b_adv;
    assign lut_valid = accept;
    assign lut_a     = in_data;
    assign lut_inv   = in_inv;
    assign lut_tag   = in_tag;
    assign a_valid   = 1'b0;
  end else if (PIPE == 2) begin : g_pipe2
    logic               a_valid_q;
    logic               a_inv_q;
    logic [8*LANES-1:0] a_data_q;
    logic [TAG_W-1:0]   a_tag_q;

    assign up_adv    = !a_valid_q || b_adv;
    assign lut_valid = a_valid_q;
    assign lut_a     = a_data_q;
    assign lut_inv   = a_inv_q;
    assign lut_tag   = a_tag_q;
    assign a_valid   = a_valid_q;

    // Stage A: capture the raw request; payload only loads on a real transfer.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        a_valid_q <= 1'b0;
        a_inv_q   <= 1'b0;
        a_data_q  <= '0;
        a_tag_q   <= '0;
      end else if (flush) begin
        a_valid_q <= 1'b0;
      end else if (up_adv) begin
        a_valid_q <= accept;
        if (accept) begin
          a_inv_q  <= in_inv;
          a_data_q <= in_data;
          a_tag_q  <= in_tag;
        end
      end
    end
  end else begin : g_bad_pipe
    $error("aes_sbox_pipe: PIPE must be 1 or 2");
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_sbox_lut u_lut (
      .a   (lut_a[8*k +: 8]),
      .inv (lut_inv),
      .d   (b_data_d[8*k +: 8])
    );
  end

  // Result stage: holds while stalled, refills in the same cycle it drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_tag_q   <= '0;
    end else if (flush) begin
      b_valid_q <= 1'b0;
    end else if (b_adv) begin
      b_valid_q <= lut_valid;
      if (lut_valid) begin
        b_data_q <= b_data_d;
        b_tag_q  <= lut_tag;
      end
    end
  end

  assign out_valid = b_valid_q;
  assign out_data  = b_data_q;
  assign out_tag   = b_tag_q;
  assign busy      = b_valid_q || a_valid;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Bench for aes_sbox_pipe: one PIPE=1 and one PIPE=2 instance (LANES=4),
// checked against an S-box model computed from GF(2^8) arithmetic.
module tb_aes_sbox_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  logic        p1_in_valid = 1'b0, p1_in_ready, p1_in_inv = 1'b0;
  logic [31:0] p1_in_data = '0, p1_out_data;
  logic [3:0]  p1_in_tag = '0, p1_out_tag;
  logic        p1_out_valid, p1_out_ready = 1'b0, p1_busy;

  logic        p2_in_valid = 1'b0, p2_in_ready, p2_in_inv = 1'b0;
  logic [31:0] p2_in_data = '0, p2_out_data;
  logic [3:0]  p2_in_tag = '0, p2_out_tag;
  logic        p2_out_valid, p2_out_ready = 1'b0, p2_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_fwd [256];
  logic [7:0]  m_inv [256];
  logic [35:0] q1 [$];
  logic [35:0] q2 [$];

  initial forever #5 clk = ~clk;

  aes_sbox_pipe #(.LANES(4), .PIPE(1), .TAG_W(4)) u_p1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(p1_in_valid), .in_ready(p1_in_ready), .in_inv(p1_in_inv),
    .in_data(p1_in_data), .in_tag(p1_in_tag),
    .out_valid(p1_out_valid), .out_ready(p1_out_ready),
    .out_data(p1_out_data), .out_tag(p1_out_tag), .busy(p1_busy)
  );

  aes_sbox_pipe #(.LANES(4), .PIPE(2), .TAG_W(4)) u_p2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(p2_in_valid), .in_ready(p2_in_ready), .in_inv(p2_in_inv),
    .in_data(p2_in_data), .in_tag(p2_in_tag),
    .out_valid(p2_out_valid), .out_ready(p2_out_ready),
    .out_data(p2_out_data), .out_tag(p2_out_tag), .busy(p2_busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v};
    t = t << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h01;
    if (x == 8'h00) b = 8'h00;
    else for (int i = 0; i < 254; i++) b = gmul(b, x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w, input logic inv);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = inv ? m_inv[w[8*k +: 8]] : m_fwd[w[8*k +: 8]];
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input bit idle);
    logic exp_r1, exp_r2;
    if (idle) begin
      p1_in_valid = 1'b0; p2_in_valid = 1'b0;
      p1_out_ready = 1'b1; p2_out_ready = 1'b1;
    end else begin
      p1_in_valid  = ($urandom_range(0, 3) != 0);
      p1_in_data   = $urandom();
      p1_in_inv    = 1'($urandom_range(0, 1));
      p1_in_tag    = 4'($urandom_range(0, 15));
      p1_out_ready = ($urandom_range(0, 3) != 0);
      p2_in_valid  = ($urandom_range(0, 3) != 0);
      p2_in_data   = $urandom();
      p2_in_inv    = 1'($urandom_range(0, 1));
      p2_in_tag    = 4'($urandom_range(0, 15));
      p2_out_ready = ($urandom_range(0, 2) != 0);
    end
    #1;
    exp_r1 = (q1.size() == 0) || p1_out_ready;
    chk("p1 rand in_ready", p1_in_ready, exp_r1);
    chk("p1 rand out_valid", p1_out_valid, q1.size() != 0);
    chk("p1 rand busy", p1_busy, q1.size() != 0);
    if (p1_out_valid && q1.size() != 0) chk("p1 rand out", {p1_out_tag, p1_out_data}, q1[0]);
    if (p1_out_valid && p1_out_ready && q1.size() != 0) void'(q1.pop_front());
    if (p1_in_valid && exp_r1) q1.push_back({p1_in_tag, sub_word(p1_in_data, p1_in_inv)});

    exp_r2 = (q2.size() < 2) || p2_out_ready;
    chk("p2 rand in_ready", p2_in_ready, exp_r2);
    chk("p2 rand busy", p2_busy, q2.size() != 0);
    if (p2_out_valid) begin
      chk("p2 rand out nonempty", q2.size() != 0, 1);
      if (q2.size() != 0) chk("p2 rand out", {p2_out_tag, p2_out_data}, q2[0]);
    end
    if (p2_out_valid && p2_out_ready && q2.size() != 0) void'(q2.pop_front());
    if (p2_in_valid && exp_r2) q2.push_back({p2_in_tag, sub_word(p2_in_data, p2_in_inv)});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] r, d, x0, x1, x2;
    logic [3:0]  t;

    for (int i = 0; i < 256; i++) m_fwd[i] = sbox_math(i[7:0]);
    for (int i = 0; i < 256; i++) m_inv[m_fwd[i]] = i[7:0];

    // reset state
    #2 rst = 1'b0;
    #1;
    chk("reset p1 out_valid", p1_out_valid, 0);
    chk("reset p1 out_data", p1_out_data, 0);
    chk("reset p1 out_tag", p1_out_tag, 0);
    chk("reset p1 busy", p1_busy, 0);
    chk("reset p1 in_ready", p1_in_ready, 0);
    chk("reset p2 out_valid", p2_out_valid, 0);
    chk("reset p2 busy", p2_busy, 0);
    chk("reset p2 in_ready", p2_in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset held p2 in_ready", p2_in_ready, 0);
    rst = 1'b1;
    #1;
    chk("release p1 in_ready", p1_in_ready, 1);
    chk("release p2 in_ready", p2_in_ready, 1);

    // PIPE=1 forward example
    p1_out_ready = 1'b1;
    p1_in_valid = 1'b1; p1_in_inv = 1'b0; p1_in_data = 32'hFF53_0100; p1_in_tag = 4'h5;
    tick();
    p1_in_valid = 1'b0;
    chk("p1 fwd example", {p1_out_valid, p1_out_tag, p1_out_data}, {1'b1, 4'h5, 32'h16ED_7C63});
    tick();
    chk("p1 fwd one-cycle valid", p1_out_valid, 0);

    // PIPE=1 inverse example
    p1_in_valid = 1'b1; p1_in_inv = 1'b1; p1_in_data = 32'h16ED_7C63; p1_in_tag = 4'hA;
    tick();
    p1_in_valid = 1'b0;
    chk("p1 inv example", {p1_out_valid, p1_out_tag, p1_out_data}, {1'b1, 4'hA, 32'hFF53_0100});
    tick();

    // Lane-0 sweep, forward then inverse, back to back
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      d = {r[31:8], i[7:0]};
      t = i[3:0];
      p1_in_valid = 1'b1; p1_in_inv = 1'b0; p1_in_data = d; p1_in_tag = t;
      tick();
      chk("p1 fwd sweep", {p1_out_valid, p1_out_tag, p1_out_data}, {1'b1, t, sub_word(d, 1'b0)});
      if (i == 8'h63) chk("p1 fwd 0x63", p1_out_data[7:0], 8'hFB);
    end
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      d = {r[31:8], m_fwd[i]};
      p1_in_valid = 1'b1; p1_in_inv = 1'b1; p1_in_data = d; p1_in_tag = i[7:4];
      tick();
      chk("p1 inv sweep lane0", p1_out_data[7:0], i[7:0]);
      chk("p1 inv sweep word", {p1_out_valid, p1_out_data}, {1'b1, sub_word(d, 1'b1)});
    end
    p1_in_valid = 1'b0;
    tick();

    // PIPE=2 back-pressure: two accepted, third refused
    x0 = 32'h0011_2233; x1 = 32'h4455_6677; x2 = 32'h8899_AABB;
    p2_out_ready = 1'b0;
    p2_in_valid = 1'b1; p2_in_inv = 1'b0; p2_in_data = x0; p2_in_tag = 4'h1;
    #1 chk("p2 bp ready 1st", p2_in_ready, 1);
    tick();
    chk("p2 bp latency not 1", p2_out_valid, 0);
    p2_in_data = x1; p2_in_tag = 4'h2;
    #1 chk("p2 bp ready 2nd", p2_in_ready, 1);
    tick();
    chk("p2 bp first out", {p2_out_valid, p2_out_tag, p2_out_data}, {1'b1, 4'h1, sub_word(x0, 1'b0)});
    p2_in_data = x2; p2_in_tag = 4'h3;
    #1 chk("p2 bp ready 3rd", p2_in_ready, 0);
    tick();
    chk("p2 bp stall hold 1", {p2_out_valid, p2_out_tag, p2_out_data}, {1'b1, 4'h1, sub_word(x0, 1'b0)});
    tick();
    chk("p2 bp stall hold 2", {p2_out_valid, p2_out_tag, p2_out_data}, {1'b1, 4'h1, sub_word(x0, 1'b0)});
    p2_out_ready = 1'b1;
    #1 chk("p2 bp ready resume", p2_in_ready, 1);
    tick();
    p2_in_valid = 1'b0;
    chk("p2 bp second out", {p2_out_valid, p2_out_tag, p2_out_data}, {1'b1, 4'h2, sub_word(x1, 1'b0)});
    tick();
    chk("p2 bp third out", {p2_out_valid, p2_out_tag, p2_out_data}, {1'b1, 4'h3, sub_word(x2, 1'b0)});
    tick();
    chk("p2 bp drained", {p2_out_valid, p2_busy}, 2'b00);

    // PIPE=2 alternating mode
    p2_in_valid = 1'b1; p2_in_inv = 1'b0; p2_in_data = 32'h0000_0000; p2_in_tag = 4'h3;
    tick();
    p2_in_inv = 1'b1; p2_in_data = 32'h6363_6363; p2_in_tag = 4'h4;
    tick();
    p2_in_valid = 1'b0;
    chk("p2 alt fwd", {p2_out_valid, p2_out_tag, p2_out_data}, {1'b1, 4'h3, 32'h6363_6363});
    tick();
    chk("p2 alt inv", {p2_out_valid, p2_out_tag, p2_out_data}, {1'b1, 4'h4, 32'h0000_0000});
    tick();
    chk("p2 alt idle", p2_out_valid, 0);

    // PIPE=2 flush with two in flight
    p2_out_ready = 1'b0;
    p2_in_valid = 1'b1; p2_in_inv = 1'b0; p2_in_data = 32'hDEAD_BEEF; p2_in_tag = 4'h5;
    tick();
    p2_in_data = 32'hCAFE_F00D; p2_in_tag = 4'h6;
    tick();
    chk("p2 flush pre busy", {p2_busy, p2_out_valid}, 2'b11);
    flush = 1'b1; p2_in_data = 32'h1234_5678;
    #1 chk("p2 flush in_ready", p2_in_ready, 0);
    tick();
    flush = 1'b0; p2_in_valid = 1'b0;
    chk("p2 flush cleared", {p2_busy, p2_out_valid}, 2'b00);
    p2_out_ready = 1'b1;
    p2_in_valid = 1'b1; p2_in_inv = 1'b1; p2_in_data = 32'h0102_0304; p2_in_tag = 4'h7;
    tick();
    p2_in_valid = 1'b0;
    tick();
    chk("p2 post flush", {p2_out_valid, p2_out_tag, p2_out_data}, {1'b1, 4'h7, sub_word(32'h0102_0304, 1'b1)});
    tick();

    // Asynchronous reset mid-stream
    p2_out_ready = 1'b0;
    p2_in_valid = 1'b1; p2_in_inv = 1'b0; p2_in_data = 32'hA5A5_5A5A; p2_in_tag = 4'h8;
    tick();
    p2_in_data = 32'h0F0F_F0F0; p2_in_tag = 4'h9;
    tick();
    p2_in_valid = 1'b0;
    chk("p2 areset pre busy", p2_busy, 1);
    #3 rst = 1'b0;
    #1;
    chk("p2 areset immediate", {p2_out_valid, p2_busy, p2_in_ready}, 3'b000);
    @(posedge clk);
    #3 rst = 1'b1;
    p2_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("p2 areset no stale", {p2_out_valid, p2_busy}, 2'b00);
    end

    // Randomized traffic on both instances against queue models
    for (int n = 0; n < 400; n++) rand_cycle(1'b0);
    for (int k = 0; k < 12 && (q1.size() != 0 || q2.size() != 0); k++) rand_cycle(1'b1);
    chk("drain p1 empty", q1.size(), 0);
    chk("drain p2 empty", q2.size(), 0);
    chk("drain busy", {p1_busy, p2_busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
